fp_norm_round: RTL and testbench

//  Downstream neighbour of the exponent adder in the FP32 multiplier datapath.

---
 rtl/fp_mul_pkg.sv | 33 +++
 rtl/fp_round_rne.sv | 36 +++
 rtl/fp_norm_round.sv | 128 ++++++++++++
 tb/tb_fp_norm_round.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// ============================================================================
// fp_mul_pkg : shared widths, constants and S1 stage record for the FP32
//              multiplier normalise/round back end.           Rev 1.0
// ============================================================================
`default_nettype none

package fp_mul_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int SIG_W   = MAN_W + 1;
  localparam int PROD_W  = 2 * SIG_W;
  localparam int E_W     = 11;
  localparam int FP_W    = 1 + EXP_W + MAN_W;

  localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;

  typedef struct packed {
    logic                  sign;
    logic signed [E_W-1:0] e;
    logic [SIG_W-1:0]      sig;
    logic                  g;
    logic                  r;
    logic                  s;
    logic                  zero;
  } s1_t;

endpackage

`default_nettype wire

// File: rtl/fp_round_rne.sv
// ============================================================================
// fp_round_rne : significand rounding; round-to-nearest-even when
//                FP_ROUND_RNE_EN is defined, truncation otherwise.   Rev 1.0
// ============================================================================
`default_nettype none

module fp_round_rne
  import fp_mul_pkg::*;
(
  input  logic [SIG_W-1:0] sig_i,
  input  logic             g_i,
  input  logic             r_i,
  input  logic             s_i,
  output logic [SIG_W-1:0] sig_o,
  output logic             carry_o
);

  logic           inc;
  logic [SIG_W:0] sum;

`ifdef FP_ROUND_RNE_EN
  assign inc = g_i & (r_i | s_i | sig_i[0]);
`else
  logic unused_grs;
  assign unused_grs = g_i ^ r_i ^ s_i;
  assign inc        = 1'b0;
`endif

  assign sum     = {1'b0, sig_i} + {{SIG_W{1'b0}}, inc};
  assign carry_o = sum[SIG_W];
  // All-ones significand rolled over: result is exactly 1.0 at the next exponent.
  assign sig_o   = carry_o ? {1'b1, {(SIG_W-1){1'b0}}} : sum[SIG_W-1:0];

endmodule

`default_nettype wire

// File: rtl/fp_norm_round.sv
// ============================================================================
// fp_norm_round : FP32 multiplier back end - bias removal, normalise, round,
//                 range check and pack; 2-stage valid/ready pipeline.
//                 Optional macro: FP_ROUND_RNE_EN (RNE rounding).   Rev 1.0
// ============================================================================
`default_nettype none

module fp_norm_round
  import fp_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              Signo,
  input  logic [EXP_W:0]    Exp_suma,
  input  logic [PROD_W-1:0] Mant_prod,
  input  logic              Es_cero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   Resultado,
  output logic              Overflow,
  output logic              Underflow
);

  s1_t             s1_q, s1_d;
  logic            s1_valid_q;
  logic            out_valid_q;
  logic [FP_W-1:0] res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic                  s2_take;
  logic                  s1_adv;
  logic [SIG_W-1:0]      sig_rnd;
  logic                  rnd_carry;
  logic signed [E_W-1:0] e_rnd;
  logic signed [E_W-1:0] exp_unb;
  logic                  unused_sig_msb;

  assign s2_take  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_take;
  assign in_ready = !rst && (!s1_valid_q || s1_adv);

  // S1: remove bias and pick the 24-bit window under the leading one.
  assign exp_unb = $signed({{(E_W-EXP_W-1){1'b0}}, Exp_suma}) - $signed(E_W'(BIAS));

  always_comb begin
    s1_d      = '0;
    s1_d.sign = Signo;
    s1_d.zero = Es_cero;
    if (Mant_prod[PROD_W-1]) begin
      s1_d.sig = Mant_prod[PROD_W-1 -: SIG_W];
      s1_d.g   = Mant_prod[PROD_W-SIG_W-1];
      s1_d.r   = Mant_prod[PROD_W-SIG_W-2];
      s1_d.s   = |Mant_prod[PROD_W-SIG_W-3:0];
      s1_d.e   = exp_unb + E_W'(1);
    end else begin
      s1_d.sig = Mant_prod[PROD_W-2 -: SIG_W];
      s1_d.g   = Mant_prod[PROD_W-SIG_W-2];
      s1_d.r   = Mant_prod[PROD_W-SIG_W-3];
      s1_d.s   = |Mant_prod[PROD_W-SIG_W-4:0];
      s1_d.e   = exp_unb;
    end
  end

  fp_round_rne u_round (
    .sig_i   (s1_q.sig),
    .g_i     (s1_q.g),
    .r_i     (s1_q.r),
    .s_i     (s1_q.s),
    .sig_o   (sig_rnd),
    .carry_o (rnd_carry)
  );

  assign e_rnd          = s1_q.e + (rnd_carry ? E_W'(1) : E_W'(0));
  assign unused_sig_msb = sig_rnd[SIG_W-1];

  // S2: zero operand outranks the range checks.
  always_comb begin
    res_d = {s1_q.sign, e_rnd[EXP_W-1:0], sig_rnd[MAN_W-1:0]};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s1_q.zero) begin
      res_d = {s1_q.sign, FP_ZERO[FP_W-2:0]};
    end else if (e_rnd >= $signed(E_W'(EXP_MAX))) begin
      res_d = {s1_q.sign, FP_POS_INF[FP_W-2:0]};
      ovf_d = 1'b1;
    end else if (e_rnd <= $signed(E_W'(0))) begin
      res_d = {s1_q.sign, FP_ZERO[FP_W-2:0]};
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
        end
      end
      if (s2_take) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_q <= res_d;
          ovf_q <= ovf_d;
          unf_q <= unf_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign Resultado = res_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_round.sv
// ============================================================================
// tb_fp_norm_round : scoreboard bench for fp_norm_round (either rounding
//                    build, selected by FP_ROUND_RNE_EN).          Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        Signo;
  logic [8:0]  Exp_suma;
  logic [47:0] Mant_prod;
  logic        Es_cero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Resultado;
  logic        Overflow;
  logic        Underflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] sb[$];
  bit rand_done;

  fp_norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Signo     (Signo),
    .Exp_suma  (Exp_suma),
    .Mant_prod (Mant_prod),
    .Es_cero   (Es_cero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Resultado (Resultado),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // Reference behaviour: {Resultado, Overflow, Underflow}
  function automatic logic [33:0] model(input logic sg, input logic [8:0] ex,
                                        input logic [47:0] mp, input logic z);
    int e;
    int m;
    logic g, r, s;
    logic [23:0] sig;
    logic [31:0] res;
    if (mp[47]) begin
      sig = mp[47:24]; g = mp[23]; r = mp[22]; s = |mp[21:0];
      e = int'(ex) - 127 + 1;
    end else begin
      sig = mp[46:23]; g = mp[22]; r = mp[21]; s = |mp[20:0];
      e = int'(ex) - 127;
    end
    m = int'(sig);
`ifdef FP_ROUND_RNE_EN
    if (g && (r || s || sig[0])) m = m + 1;
`else
    if (g || r || s) m = m + 0;
`endif
    if (m >= (1 << 24)) begin
      m = 1 << 23;
      e = e + 1;
    end
    if (z) return {sg, 31'b0, 2'b00};
    if (e >= 255) return {sg, 8'hFF, 23'b0, 2'b10};
    if (e <= 0) return {sg, 31'b0, 2'b01};
    res = {sg, e[7:0], m[22:0]};
    return {res, 2'b00};
  endfunction

  always @(negedge clk) begin
    logic [33:0] ev;
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got res=%h ovf=%b unf=%b, none expected",
                 Resultado, Overflow, Underflow);
      end else begin
        ev = sb.pop_front();
        if ({Resultado, Overflow, Underflow} !== ev) begin
          n_fail++;
          $display("FAIL result: got res=%h ovf=%b unf=%b, expected res=%h ovf=%b unf=%b",
                   Resultado, Overflow, Underflow, ev[33:2], ev[1], ev[0]);
        end
      end
    end
  end

  // Phase invariant: tasks start and end at posedge+#1.
  task automatic send(input logic sg, input logic [8:0] ex, input logic [47:0] mp,
                      input logic z, input logic [33:0] ev);
    bit acc = 0;
    Signo = sg; Exp_suma = ex; Mant_prod = mp; Es_cero = z; in_valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (acc) begin
      sb.push_back(ev);
      @(posedge clk); #1;
    end else begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%b, required 1 within 300 cycles", in_ready);
    end
  endtask

  task automatic send_m(input logic sg, input logic [8:0] ex, input logic [47:0] mp,
                        input logic z);
    send(sg, ex, mp, z, model(sg, ex, mp, z));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Signo = 1'b0; Exp_suma = '0; Mant_prod = '0; Es_cero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (Resultado !== 32'h0) begin n_fail++; $display("FAIL rst_resultado: got %h, required 0", Resultado); end
    if (Overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b, required 0", Overflow); end
    if (Underflow !== 1'b0) begin n_fail++; $display("FAIL rst_underflow: got %b, required 0", Underflow); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send(1'b0, 9'd254, 48'h4000_0000_0000, 1'b0, {32'h3F80_0000, 2'b00});
    idle();
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency: out_valid=%b two cycles after accept, required 1", out_valid); end
    @(posedge clk); #1;
    send(1'b0, 9'd254, 48'h9000_0000_0000, 1'b0, {32'h4010_0000, 2'b00});
`ifdef FP_ROUND_RNE_EN
    send(1'b0, 9'd254, 48'h7FFF_FFC0_0000, 1'b0, {32'h4000_0000, 2'b00});
`else
    send(1'b0, 9'd254, 48'h7FFF_FFC0_0000, 1'b0, {32'h3FFF_FFFF, 2'b00});
`endif
    idle();
    wait_drain();
  endtask

  task automatic test_range();
    send(1'b0, 9'd400, 48'h4000_0000_0000, 1'b0, {32'h7F80_0000, 2'b10});
    send(1'b1, 9'd100, 48'h4000_0000_0000, 1'b0, {32'h8000_0000, 2'b01});
    send(1'b1, 9'd381, 48'h4000_0000_0000, 1'b0, {32'hFF7F_FFFF & 32'hFF00_0000 | 32'h7F00_0000 & 32'h7F00_0000, 2'b00});
    send(1'b0, 9'd382, 48'h4000_0000_0000, 1'b0, {32'h7F80_0000, 2'b10});
    send(1'b0, 9'd128, 48'h4000_0000_0000, 1'b0, {32'h0080_0000, 2'b00});
    send(1'b0, 9'd127, 48'h4000_0000_0000, 1'b0, {32'h0000_0000, 2'b01});
    send(1'b0, 9'd127, 48'h8000_0000_0000, 1'b0, {32'h0080_0000, 2'b00});
    idle();
    wait_drain();
  endtask

  task automatic test_zero();
    send(1'b1, 9'd400, 48'h4000_0000_0000, 1'b1, {32'h8000_0000, 2'b00});
    send(1'b0, 9'd10,  48'h9000_0000_0000, 1'b1, {32'h0000_0000, 2'b00});
    idle();
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 9'd254, 48'h4000_0000_0000, 1'b0, {32'h3F80_0000, 2'b00});
        send(1'b0, 9'd254, 48'h9000_0000_0000, 1'b0, {32'h4010_0000, 2'b00});
        send(1'b1, 9'd50,  48'h4000_0000_0000, 1'b0, {32'h8000_0000, 2'b01});
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests += 3;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        if (sb.size() != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d accepted, required 2", sb.size()); end
        if (out_valid !== 1'b1 || Resultado !== 32'h3F80_0000) begin
          n_fail++;
          $display("FAIL bp_head: got valid=%b res=%h, required valid=1 res=3f800000", out_valid, Resultado);
        end
        held = Resultado;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          n_tests++;
          if (out_valid !== 1'b1 || Resultado !== held) begin
            n_fail++;
            $display("FAIL bp_stable: got valid=%b res=%h, required valid=1 res=%h", out_valid, Resultado, held);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [23:0] a, b;
    rand_done = 0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          a = {1'b1, 23'($urandom)};
          b = {1'b1, 23'($urandom)};
          send_m(1'($urandom), 9'($urandom_range(90, 420)), 48'(a) * 48'(b),
                 ($urandom_range(0, 7) == 0));
        end
        idle();
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    Signo = 1'b0; Exp_suma = 9'd254; Mant_prod = 48'h4000_0000_0000; Es_cero = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_accept: in_ready=%b, required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_in_ready: got %b during reset, required 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b after reset, required 0", out_valid); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
